vga_sprite_overlay: RTL and testbench
=====================================

// Module: vga_sprite_overlay
// PURPOSE
//  640x480@60 Hz VGA timing generator fused with a single-bitmap sprite renderer (e.g. "game over"
//  banner). Produces HS/VS/blank and pixel coordinates, addresses an external synchronous sprite ROM
//  and outputs RGB332 colour for pixels inside a programmable rectangle. Sits between the 25 MHz
//  pixel-clock divider and the top-level colour mux.
// PARAMETERS
//  H_VISIBLE 640 active pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48   (line total 800)
//  V_VISIBLE 480 active lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33   (frame total 525)
//  ADDR_W    15  sprite ROM address width
//  PIX_W      8  sprite ROM data width (RGB332)
// PORTS
//  pixel_clk  in   1       25 MHz pixel clock; sole clock
//  rst        in   1       asynchronous, active-low reset
//  x0,y0      in   11      sprite top-left (inclusive), screen pixels
//  x1,y1      in   11      sprite bottom-right (exclusive)
//  mem_value  in   PIX_W   ROM data, valid 1 cycle after rom_addr
//  rom_addr   out  ADDR_W  sprite ROM address
//  hcounter   out  11      current pixel column 0..799
//  vcounter   out  11      current line 0..524
//  HS, VS     out  1       sync, active-low
//  blank      out  1       1 when hcounter>=640 or vcounter>=480
//  R,G        out  3       red/green colour
//  B          out  2       blue colour
// BEHAVIOUR
//  - Reset (rst=0, async): hcounter=vcounter=0, HS=VS=1, blank=0, rom_addr=0, R=G=B=0.
//  - hcounter increments each pixel_clk; at 799 wraps to 0 and vcounter increments; vcounter wraps
//    524->0 on the same edge that hcounter wraps 799->0.
//  - HS=0 exactly for hcounter 656..751; VS=0 exactly for vcounter 490..491. Both registered,
//    updated on the same edge as counters (no skew vs counters).
//  - blank is combinational from the registered counters.
//  - inwin = ~blank & hcounter>=x0 & hcounter<x1 & vcounter>=y0 & vcounter<y1 (unsigned).
//    x1<=x0 or y1<=y0 -> never inside.
//  - rom_addr (combinational) = (vcounter-y0)*(x1-x0) + (hcounter-x0), truncated to ADDR_W when
//    inwin; 0 otherwise. Row-major, no padding between rows.
//  - Pipeline: inwin delayed 1 cycle to align with mem_value; R/G/B registered on next edge.
//    Colour for counter value at cycle t appears on R/G/B at cycle t+2.
//  - Colour: delayed inwin=1 -> R=mem_value[7:5], G=mem_value[4:2], B=mem_value[1:0];
//    else R=G=B=0 (black during blanking and outside window).
//  - x0..y1 sampled combinationally every cycle; changing mid-frame takes effect immediately.
//  - Reset mid-frame: all state to reset values; pipeline flushed (RGB 0 for first 2 cycles).
// STRUCTURE
//  - Package vga_timing_pkg: H_/V_ timing constants, H_TOTAL=800, V_TOTAL=525, HS/VS start/end
//    derived constants, RGB332 field slice localparams.
//  - Sub-module vga_timing_gen: counters, HS/VS, blank. Top adds window compare, address
//    multiply-add, 2-stage colour pipeline.
// TESTING
//  - Reset: hold rst=0 3 cycles -> hcounter=vcounter=0, HS=VS=1, RGB=0; release -> hcounter 1 next edge.
//  - Line timing: HS falls when hcounter becomes 656, low 96 cycles, rises at 752; blank=1 at h=640.
//  - Frame timing: VS low for vcounter 490,491 only; 420000 cycles between VS falling edges.
//  - Window x0=150,y0=150,x1=493,y1=197: rom_addr=0 at (150,150), 1 at (151,150), 343 at (150,151),
//    16120 at (492,196); 0 at (149,150) and (493,150).
//  - ROM model returns 0xE3 for all addresses: at (150,150) R=7,G=0,B=3 two cycles later;
//    RGB=0 outside window and for whole blanking interval; x1=x0 -> RGB always 0.
//  - Assert rst mid-line at h=300,v=200 -> counters 0 immediately, HS/VS=1, RGB 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, RGB332 field layout and a half-open range helper
// for the VGA sprite overlay.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned H_FP         = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BP         = 48;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned V_FP         = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BP         = 33;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned PIX_W_DEF  = 8;

  localparam int unsigned R_MSB = 7;
  localparam int unsigned R_LSB = 5;
  localparam int unsigned G_MSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_MSB = 1;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // True when lo <= val < hi; an empty or inverted span never matches.
  function automatic logic in_span(input logic [CNT_W-1:0] val,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with registered active-low sync pulses and a combinational
// blank flag derived from the registered counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP
) (
  input  logic             pixel_clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             blank_o
);

  localparam int unsigned HTOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HSS  = H_VISIBLE + H_FP;
  localparam int unsigned HSE  = HSS + H_SYNC;
  localparam int unsigned VTOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned VSS  = V_VISIBLE + V_FP;
  localparam int unsigned VSE  = VSS + V_SYNC;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             h_wrap;

  always_comb begin
    h_wrap = (h_q == CNT_W'(HTOT - 1));
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == CNT_W'(VTOT - 1)) ? '0 : v_q + 1'b1;
    end
    // Sync decodes the next counter values so it lands on the same edge as the counters.
    hs_d = ~in_span(h_d, CNT_W'(HSS), CNT_W'(HSE));
    vs_d = ~in_span(v_d, CNT_W'(VSS), CNT_W'(VSE));
  end

  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign hcount_o = h_q;
  assign vcount_o = v_q;
  assign hs_o     = hs_q;
  assign vs_o     = vs_q;
  assign blank_o  = (h_q >= CNT_W'(H_VISIBLE)) || (v_q >= CNT_W'(V_VISIBLE));

endmodule

// File: rtl/vga_sprite_overlay.sv
// VGA timing plus a single rectangular sprite fetched row-major from an external
// synchronous ROM; colour is valid two cycles after the counters that produced it.
module vga_sprite_overlay
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned PIX_W     = PIX_W_DEF
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  x0,
  input  logic [CNT_W-1:0]  y0,
  input  logic [CNT_W-1:0]  x1,
  input  logic [CNT_W-1:0]  y1,
  input  logic [PIX_W-1:0]  mem_value,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CNT_W-1:0]  hcounter,
  output logic [CNT_W-1:0]  vcounter,
  output logic              HS,
  output logic              VS,
  output logic              blank,
  output logic [2:0]        R,
  output logic [2:0]        G,
  output logic [1:0]        B
);

  localparam int unsigned PROD_W = 2 * CNT_W;

  logic             inwin, inwin_q;
  logic [CNT_W-1:0] dx, dy, dw;
  rgb332_t          rgb_q, rgb_d;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .pixel_clk_i (pixel_clk),
    .rst_ni      (rst),
    .hcount_o    (hcounter),
    .vcount_o    (vcounter),
    .hs_o        (HS),
    .vs_o        (VS),
    .blank_o     (blank)
  );

  always_comb begin
    inwin = ~blank & in_span(hcounter, x0, x1) & in_span(vcounter, y0, y1);
    dx    = hcounter - x0;
    dy    = vcounter - y0;
    dw    = x1 - x0;
    // Full-width product, then truncate: the ROM wraps for sprites larger than 2**ADDR_W.
    rom_addr = inwin ? ADDR_W'(PROD_W'(dy) * PROD_W'(dw) + PROD_W'(dx)) : '0;

    rgb_d = '0;
    if (inwin_q) begin
      rgb_d.r = mem_value[R_MSB:R_LSB];
      rgb_d.g = mem_value[G_MSB:G_LSB];
      rgb_d.b = mem_value[B_MSB:B_LSB];
    end
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      inwin_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      inwin_q <= inwin;
      rgb_q   <= rgb_d;
    end
  end

  assign R = rgb_q.r;
  assign G = rgb_q.g;
  assign B = rgb_q.b;

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Randomized bench for vga_sprite_overlay: a full-size instance and a shrunken-timing
// instance are both compared each cycle against an arithmetic reference model.
module tb_vga_sprite_overlay;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } tim_t;

  typedef struct {
    int h, v, addr;
    bit hs, vs, blank, inwin;
  } exp_t;

  typedef struct {
    int h, v, a;
  } pt_t;

  localparam int S_FRAME = (40 + 4 + 6 + 5) * (10 + 2 + 2 + 3);

  tim_t m_t = '{640, 16, 96, 48, 480, 10, 2, 33};
  tim_t s_t = '{40, 4, 6, 5, 10, 2, 2, 3};
  pt_t  pts[6] = '{'{150, 2, 0}, '{151, 2, 1}, '{150, 3, 343},
                   '{492, 48, 16120}, '{149, 2, 0}, '{493, 2, 0}};

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [10:0] mx0, my0, mx1, my1, sx0, sy0, sx1, sy1;
  logic [7:0]  m_mem, s_mem;
  logic [14:0] m_addr, s_addr;
  logic [10:0] m_h, m_v, s_h, s_v;
  logic        m_hs, m_vs, m_blank, s_hs, s_vs, s_blank;
  logic [2:0]  m_r, m_g, s_r, s_g;
  logic [1:0]  m_b, s_b;

  bit          rom_hash;
  bit          directed;
  int unsigned n;
  int unsigned n_cmp, n_err;
  logic [7:0]  m_c1, m_c2, s_c1, s_c2;
  int          hs_low, s_last_fall;
  logic        s_vs_prev;

  always #20 pixel_clk = ~pixel_clk;

  vga_sprite_overlay u_dut (
    .pixel_clk (pixel_clk), .rst (rst),
    .x0 (mx0), .y0 (my0), .x1 (mx1), .y1 (my1),
    .mem_value (m_mem), .rom_addr (m_addr),
    .hcounter (m_h), .vcounter (m_v), .HS (m_hs), .VS (m_vs), .blank (m_blank),
    .R (m_r), .G (m_g), .B (m_b)
  );

  vga_sprite_overlay #(
    .H_VISIBLE (40), .H_FP (4), .H_SYNC (6), .H_BP (5),
    .V_VISIBLE (10), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) u_small (
    .pixel_clk (pixel_clk), .rst (rst),
    .x0 (sx0), .y0 (sy0), .x1 (sx1), .y1 (sy1),
    .mem_value (s_mem), .rom_addr (s_addr),
    .hcounter (s_h), .vcounter (s_v), .HS (s_hs), .VS (s_vs), .blank (s_blank),
    .R (s_r), .G (s_g), .B (s_b)
  );

  function automatic logic [7:0] rom_fn(input logic [14:0] a, input bit hashed);
    logic [31:0] t;
    t = ({17'b0, a} * 32'd151) ^ ({17'b0, a} >> 7);
    return hashed ? t[7:0] : 8'hE3;
  endfunction

  // Synchronous sprite ROM: data appears one cycle after the address.
  always @(posedge pixel_clk) begin
    m_mem <= rom_fn(m_addr, rom_hash);
    s_mem <= rom_fn(s_addr, rom_hash);
  end

  function automatic exp_t model(input int unsigned cyc, input tim_t t,
                                 input int wx0, input int wy0, input int wx1, input int wy1);
    exp_t e;
    int   htot, vtot;
    htot    = t.hv + t.hf + t.hs + t.hb;
    vtot    = t.vv + t.vf + t.vs + t.vb;
    e.h     = int'(cyc) % htot;
    e.v     = (int'(cyc) / htot) % vtot;
    e.hs    = !(e.h >= t.hv + t.hf && e.h < t.hv + t.hf + t.hs);
    e.vs    = !(e.v >= t.vv + t.vf && e.v < t.vv + t.vf + t.vs);
    e.blank = (e.h >= t.hv) || (e.v >= t.vv);
    e.inwin = !e.blank && e.h >= wx0 && e.h < wx1 && e.v >= wy0 && e.v < wy1;
    e.addr  = e.inwin ? (((e.v - wy0) * (wx1 - wx0) + (e.h - wx0)) % 32768) : 0;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_m"}, {m_h, m_v, m_hs, m_vs, m_blank, m_addr, m_r, m_g, m_b},
              {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 15'd0, 8'd0});
    check_val({tag, "_s"}, {s_h, s_v, s_hs, s_vs, s_blank, s_addr, s_r, s_g, s_b},
              {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 15'd0, 8'd0});
  endtask

  task automatic check_cycle();
    exp_t em, es;
    em = model(n, m_t, int'(mx0), int'(my0), int'(mx1), int'(my1));
    es = model(n, s_t, int'(sx0), int'(sy0), int'(sx1), int'(sy1));

    check_val("m_timing", {m_h, m_v, m_hs, m_vs, m_blank},
              {11'(em.h), 11'(em.v), em.hs, em.vs, em.blank});
    check_val("m_pixel", {m_addr, m_r, m_g, m_b}, {15'(em.addr), m_c2});
    check_val("s_timing", {s_h, s_v, s_hs, s_vs, s_blank},
              {11'(es.h), 11'(es.v), es.hs, es.vs, es.blank});
    check_val("s_pixel", {s_addr, s_r, s_g, s_b}, {15'(es.addr), s_c2});

    m_c2 = m_c1;
    m_c1 = em.inwin ? rom_fn(15'(em.addr), rom_hash) : 8'h00;
    s_c2 = s_c1;
    s_c1 = es.inwin ? rom_fn(15'(es.addr), rom_hash) : 8'h00;

    if (directed) begin
      foreach (pts[i]) begin
        if (em.h == pts[i].h && em.v == pts[i].v)
          check_val($sformatf("addr_%0d_%0d", pts[i].h, pts[i].v), 64'(m_addr), 64'(pts[i].a));
      end
      if (em.h == 152 && em.v == 2)
        check_val("rgb_150_2", {m_r, m_g, m_b}, {3'd7, 3'd0, 2'd3});
    end

    if (!m_hs) hs_low++;
    else if (hs_low != 0) begin
      check_val("hs_low_len", 64'(hs_low), 64'd96);
      hs_low = 0;
    end

    if (s_vs_prev && !s_vs) begin
      if (s_last_fall >= 0) check_val("vs_period", 64'(int'(n) - s_last_fall), 64'(S_FRAME));
      s_last_fall = int'(n);
    end
    s_vs_prev = s_vs;
  endtask

  task automatic start_run();
    n           = 0;
    m_c1        = '0;
    m_c2        = '0;
    s_c1        = '0;
    s_c2        = '0;
    hs_low      = 0;
    s_last_fall = -1;
    s_vs_prev   = 1'b1;
    check_cycle();
  endtask

  task automatic new_small_window();
    sx0 = 11'($urandom_range(0, 55));
    sx1 = 11'($urandom_range(0, 56));
    sy0 = 11'($urandom_range(0, 17));
    sy1 = 11'($urandom_range(0, 18));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    rom_hash = 1'b0;
    directed = 1'b1;
    mx0 = 11'd150; my0 = 11'd2; mx1 = 11'd493; my1 = 11'd49;
    new_small_window();

    repeat (3) @(posedge pixel_clk);
    #1 check_reset("por");
    @(negedge pixel_clk);
    rst = 1'b1;
    #1 start_run();

    // Constant 0xE3 ROM, fixed sprite window, down to line 50 column 300.
    while (n < 50 * 800 + 300) begin
      @(posedge pixel_clk);
      #1 n++;
      if (n % 97 == 0) new_small_window();
      #1 check_cycle();
    end

    #5 rst = 1'b0;
    #1 check_reset("mid_line");
    directed = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1 check_reset("hold");
    rom_hash = 1'b1;
    @(negedge pixel_clk);
    rst = 1'b1;
    #1 start_run();

    // Hashed ROM with randomized windows, including an empty x1==x0 window.
    while (n < 8000) begin
      @(posedge pixel_clk);
      #1 n++;
      if (n % 400 == 0) begin
        mx0 = 11'($urandom_range(0, 700));
        mx1 = (n / 400 == 3) ? mx0 : 11'($urandom_range(0, 800));
        my0 = 11'($urandom_range(0, 8));
        my1 = 11'($urandom_range(0, 12));
      end
      if (n % 97 == 0) new_small_window();
      #1 check_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
